mem_port_arbiter: RTL

//  Shares one single-port unified memory between IF (instr fetch) and MEM (load/store) stages of the xgriscv pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/arb_starve_cnt.sv | 36 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_IF = 1'b0,
        ARB_OWN_D  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive MEM grants taken while a fetch was waiting.
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q >= MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM onto one single-port memory, one outstanding access at a time.
// Handshake: a command transfers when m_req & m_ready; the response is one m_rvalid pulse in WAIT.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flushF,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stallF,
    output logic              stallM,
    output logic              m_req,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wmask,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output arb_state_e        dbg_state_o
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              drop_q, drop_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [3:0]        m_wmask_q, m_wmask_d;
    logic              grant_d, grant_if, starve_sat;

    arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk  (clk),
        .reset(reset),
        .inc  (grant_d && if_req),
        .clr  (grant_if),
        .sat  (starve_sat)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        drop_d    = drop_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wmask_d = m_wmask_q;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_req && (!starve_sat || !if_req)) begin
                    grant_d   = 1'b1;
                    owner_d   = ARB_OWN_D;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_wmask_d = d_wmask;
                    state_d   = ARB_REQ;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    owner_d   = ARB_OWN_IF;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    m_wmask_d = '0;
                    state_d   = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (m_ready) state_d = ARB_WAIT;
                if (flushF && owner_q == ARB_OWN_IF) drop_d = 1'b1;
            end
            ARB_WAIT: begin
                if (m_rvalid) begin
                    state_d = ARB_IDLE;
                    drop_d  = 1'b0;
                end else if (flushF && owner_q == ARB_OWN_IF) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                drop_d  = 1'b0;
            end
        endcase
        m_req_d = (state_d == ARB_REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= ARB_OWN_IF;
            drop_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            drop_q    <= drop_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wmask_q <= m_wmask_d;
        end
    end

    // A flush landing together with the response still discards the fetch.
    assign if_rvalid = (state_q == ARB_WAIT) && m_rvalid && (owner_q == ARB_OWN_IF)
                       && !drop_q && !flushF;
    assign d_rvalid  = (state_q == ARB_WAIT) && m_rvalid && (owner_q == ARB_OWN_D);
    assign if_rdata  = if_rvalid ? m_rdata : '0;
    assign d_rdata   = d_rvalid ? m_rdata : '0;

    assign stallF = if_req && !if_rvalid;
    assign stallM = d_req && !d_rvalid;

    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign m_wmask     = m_wmask_q;
    assign dbg_state_o = state_q;

endmodule
